// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter
//   Two-port round-robin arbiter in front of a bank of NUM_REGS 16-bit
//   load-enabled registers. Each transaction runs IDLE -> ACCESS -> DONE.
//   Only one access is in flight at a time.
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   req0/we0/addr0/wdata0   requester 0 request (held until ack0)
//   ack0, rdata0            requester 0 one-cycle ack and read/echo data
//   req1/we1/addr1/wdata1   requester 1 request (held until ack1)
//   ack1, rdata1            requester 1 one-cycle ack and read/echo data
//   busy                    high whenever the FSM is outside IDLE

// Load-enabled storage cell with no reset; contents are undefined until
// the first write.
module reg_bank_cell #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk)
    if (load) q <= d;
endmodule

module reg_bank_arbiter #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                            state;
  logic                              last_grant;
  logic                              sel;
  logic                              we_l;
  logic [ADDR_W-1:0]                 addr_l;
  logic [DATA_W-1:0]                 wdata_l;

  logic [NUM_REGS-1:0]               load;
  logic [NUM_REGS-1:0][DATA_W-1:0]   bank_q;
  logic                              gnt;
  logic [DATA_W-1:0]                 rd_cap;

  // Winner for the IDLE cycle. A tie goes to the requester that did not
  // win last time; a single request simply wins.
  always_comb begin
    gnt = req1;
    if (req0 && req1) gnt = ~last_grant;
  end

  // One-hot load decode. The load is gated by reset so that a write caught
  // in ACCESS on a reset edge leaves the bank untouched.
  always_comb begin
    load = '0;
    if (state == ACCESS && we_l && !reset) load[addr_l] = 1'b1;
  end

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_bank
      reg_bank_cell #(.DATA_W(DATA_W)) u_cell (
        .clk  (clk),
        .load (load[g]),
        .d    (wdata_l),
        .q    (bank_q[g])
      );
    end
  endgenerate

  // A write echoes the data being written; a read returns the current
  // register value, which is read combinationally from the array.
  assign rd_cap = we_l ? wdata_l : bank_q[addr_l];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      busy       <= 1'b0;
      last_grant <= 1'b1;
      sel        <= 1'b0;
      we_l       <= 1'b0;
      addr_l     <= '0;
      wdata_l    <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          if (req0 || req1) begin
            sel        <= gnt;
            we_l       <= gnt ? we1    : we0;
            addr_l     <= gnt ? addr1  : addr0;
            wdata_l    <= gnt ? wdata1 : wdata0;
            last_grant <= gnt;
            busy       <= 1'b1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          // Ack and data are registered here so they are valid for the
          // whole DONE cycle. The loser's rdata is left untouched.
          if (sel) begin
            ack1   <= 1'b1;
            rdata1 <= rd_cap;
          end else begin
            ack0   <= 1'b1;
            rdata0 <= rd_cap;
          end
          state <= DONE;
        end
        DONE: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
module tb_reg_bank_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [2:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1, busy;
  logic [15:0] rdata0, rdata1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: register contents, last winner, each port's rdata.
  logic [15:0] mem [8];
  logic        last_g;
  logic [15:0] mdl_rd [2];

  reg_bank_arbiter #(.NUM_REGS(8), .ADDR_W(3), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk1({tag, " ack0"}, ack0, 1'b0);
    chk1({tag, " ack1"}, ack1, 1'b0);
    chk1({tag, " busy"}, busy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    last_g    = 1'b1;
    mdl_rd[0] = '0;
    mdl_rd[1] = '0;
    chk_quiet("reset");
    chk16("reset rdata0", rdata0, 16'h0);
    chk16("reset rdata1", rdata1, 16'h0);
    reset = 1'b0;
  endtask

  // Raise the selected requests together from an IDLE cycle and follow
  // the transaction(s) to completion. Timing seen at negedges after the
  // raise: first ack at cycle 2; with a tie, an IDLE gap at cycle 3 and
  // the second ack at cycle 5.
  task automatic run_pair(
    input logic r0, input logic w0, input logic [2:0] a0, input logic [15:0] d0,
    input logic r1, input logic w1, input logic [2:0] a1, input logic [15:0] d1);
    int first, second, last_k;
    logic e0, e1;
    @(negedge clk);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    if (r0 && r1) begin
      first  = (last_g == 1'b0) ? 1 : 0;
      second = 1 - first;
      last_k = 5;
      last_g = logic'(second);
    end else begin
      first  = r1 ? 1 : 0;
      second = -1;
      last_k = 2;
      last_g = logic'(first);
    end
    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk);
      e0 = (k == 2 && first == 0) || (k == 5 && second == 0);
      e1 = (k == 2 && first == 1) || (k == 5 && second == 1);
      if (e0) begin
        mdl_rd[0] = w0 ? d0 : mem[a0];
        if (w0) mem[a0] = d0;
      end
      if (e1) begin
        mdl_rd[1] = w1 ? d1 : mem[a1];
        if (w1) mem[a1] = d1;
      end
      chk1("txn ack0", ack0, e0);
      chk1("txn ack1", ack1, e1);
      chk1("txn busy", busy, k != 3);
      chk16("txn rdata0", rdata0, mdl_rd[0]);
      chk16("txn rdata1", rdata1, mdl_rd[1]);
      if (e0) req0 = 1'b0;
      if (e1) req1 = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] rv;
    reset = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    for (int i = 0; i < 8; i++) mem[i] = 'x;
    repeat (2) @(negedge clk);
    last_g = 1'b1;
    mdl_rd[0] = '0;
    mdl_rd[1] = '0;
    chk_quiet("por");
    chk16("por rdata0", rdata0, 16'h0);
    chk16("por rdata1", rdata1, 16'h0);
    reset = 1'b0;

    // single write then read on port 0
    run_pair(1, 1, 3'd3, 16'hBEEF, 0, 0, 3'd0, 16'h0);
    run_pair(1, 0, 3'd3, 16'h0000, 0, 0, 3'd0, 16'h0);
    chk16("beef readback", rdata0, 16'hBEEF);

    // give every register a known value
    for (int i = 0; i < 8; i++) begin
      rv = $urandom;
      run_pair(i[0] == 1'b0, 1, 3'(i), rv[15:0], i[0] == 1'b1, 1, 3'(i), rv[31:16]);
    end

    // tie right after reset: port 0 first
    do_reset();
    run_pair(1, 0, 3'd1, 16'h0, 1, 0, 3'd6, 16'h0);

    // round robin, each side writing its own address, then readback
    run_pair(1, 1, 3'd0, 16'h1111, 1, 1, 3'd1, 16'h2222);
    run_pair(1, 1, 3'd4, 16'h3333, 1, 1, 3'd6, 16'h4444);
    run_pair(1, 0, 3'd0, 16'h0, 1, 0, 3'd1, 16'h0);
    run_pair(1, 0, 3'd4, 16'h0, 1, 0, 3'd6, 16'h0);

    // same-address race with last winner = 1
    run_pair(1, 1, 3'd5, 16'h1234, 1, 0, 3'd5, 16'h0);
    chk16("race rdata1", rdata1, 16'h1234);

    // reset during ACCESS of a write
    run_pair(1, 1, 3'd2, 16'hAAAA, 0, 0, 3'd0, 16'h0);
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 3'd2; wdata0 = 16'h5555;
    @(negedge clk);
    chk1("midrst busy in access", busy, 1'b1);
    reset = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    last_g = 1'b1;
    mdl_rd[0] = '0;
    mdl_rd[1] = '0;
    chk_quiet("midrst after");
    chk16("midrst rdata0", rdata0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_quiet("midrst settle");
    end
    run_pair(0, 0, 3'd0, 16'h0, 1, 0, 3'd2, 16'h0);
    chk16("midrst readback", rdata1, 16'hAAAA);

    // no requests for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_quiet("idle");
    end
    for (int i = 0; i < 8; i += 2)
      run_pair(1, 0, 3'(i), 16'h0, 1, 0, 3'(i + 1), 16'h0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic [1:0] m;
      rv = $urandom;
      m = rv[1:0];
      if (m == 2'b00) m = 2'b11;
      run_pair(m[0], rv[2], rv[5:3], rv[21:6], m[1], rv[22], rv[25:23], $urandom_range(0, 65535)
);
    end

    // final full readback
    for (int i = 0; i < 8; i += 2)
      run_pair(1, 0, 3'(i + 1), 16'h0, 1, 0, 3'(i), 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
